// File: rtl/seradd_pkg.sv
// seradd_pkg: shared FSM state encoding and default sizing for bit_serial_add_arb.
package seradd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: single-bit full adder, the one arithmetic cell shared by all requesters.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_add_arb.sv
// bit_serial_add_arb: round-robin arbitrated, LSB-first bit-serial adder over one fa_cell.
// Define SERADD_OVF_EN to add the rsp_ovf two's-complement overflow output.
module bit_serial_add_arb
    import seradd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
`ifdef SERADD_OVF_EN
    output logic                    rsp_ovf,
`endif
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    state_t           r_state, w_next;
    logic [IDW-1:0]   r_last_grant, r_id, w_gnt_id, w_idx;
    logic             w_gnt_vld, w_accept, w_last_bit, w_sum, w_cout, r_cy;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;

    // Scan from farthest to nearest after last_grant so the nearest valid index wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDW'((int'(r_last_grant) + k) % NREQ);
            if (req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_idx;
            end
        end
    end

    assign w_accept   = (r_state == IDLE) && w_gnt_vld && !rst;
    assign req_ready  = w_accept ? (NREQ'(1) << w_gnt_id) : '0;
    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

    fa_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_cy),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE && w_accept)   ? RUN  :
                 (r_state == RUN  && w_last_bit) ? DONE :
                 (r_state == DONE && rsp_ready)  ? IDLE : r_state;
    end

    // Operands shift right so bit 0 always feeds the cell; the sum fills in from the MSB side.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDW'(NREQ - 1);
            r_id         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_cy         <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt_id;
            r_id         <= w_gnt_id;
            r_a          <= req_a[int'(w_gnt_id)*WIDTH +: WIDTH];
            r_b          <= req_b[int'(w_gnt_id)*WIDTH +: WIDTH];
            r_cy         <= req_cin[w_gnt_id];
            r_sum        <= '0;
            r_cnt        <= '0;
        end else if (r_state == RUN) begin
            r_a          <= r_a >> 1;
            r_b          <= r_b >> 1;
            r_sum        <= {w_sum, r_sum[WIDTH-1:1]};
            r_cy         <= w_cout;
            r_cnt        <= r_cnt + 1'b1;
        end
    end

    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = rsp_valid ? r_sum : '0;
    assign rsp_cout  = rsp_valid & r_cy;

`ifdef SERADD_OVF_EN
    logic r_ovf;

    // Overflow is the carry into the MSB differing from the carry out of it.
    always_ff @(posedge clk) begin
        if (rst)                            r_ovf <= 1'b0;
        else if (r_state == RUN && w_last_bit) r_ovf <= r_cy ^ w_cout;
    end

    assign rsp_ovf = rsp_valid & r_ovf;
`endif

endmodule

// File: tb/tb_bit_serial_add_arb.sv
// tb_bit_serial_add_arb: directed vectors with a response scoreboard for bit_serial_add_arb.
module tb_bit_serial_add_arb;

    localparam int W = 8;
    localparam int N = 2;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic           clk, rst, rr;
    logic [N-1:0]   req_valid, req_ready, req_cin;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_cout, busy;
    logic [0:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
`ifdef SERADD_OVF_EN
    logic           rsp_ovf;
`endif
    logic [W-1:0]   a_v [N];
    logic [W-1:0]   b_v [N];
    logic           c_v [N];
    logic           v_v [N];
    exp_t           q [$];
    int             checks = 0;
    int             failures = 0;

    bit_serial_add_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rr),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef SERADD_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_v[i];
            req_b[i*W +: W] = b_v[i];
            req_cin[i]      = c_v[i];
            req_valid[i]    = v_v[i];
        end
    end

    // Monitor: grant exclusivity every cycle, and scoreboard pop on each response handshake.
    always @(negedge clk) begin
        exp_t e;
        logic ovf_bad;
        checks++;
        if ($countones(req_ready) > 1 || (busy && req_ready != '0)) begin
            failures++;
            $display("FAIL ready_excl got ready=%b busy=%b, need onehot0 and zero while busy", req_ready, busy);
        end
        if (!rst && rsp_valid && rr) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp got id=%0d sum=%h cout=%b, need no response", rsp_id, rsp_sum, rsp_cout);
            end else begin
                e = q.pop_front();
                ovf_bad = 1'b0;
`ifdef SERADD_OVF_EN
                ovf_bad = (rsp_ovf !== e.ovf);
`endif
                if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_cout !== e.cout || ovf_bad) begin
                    failures++;
                    $display("FAIL rsp_data got id=%0d sum=%h cout=%b, need id=%0d sum=%h cout=%b ovf=%b",
                             rsp_id, rsp_sum, rsp_cout, e.id, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h need=%h", name, got, exp);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
        int n;
        a_v[i] = a;
        b_v[i] = b;
        c_v[i] = c;
        v_v[i] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 200);
        checks++;
        if (!req_ready[i]) begin
            failures++;
            $display("FAIL grant_wait req%0d got no grant, need grant within 200 cycles", i);
        end
        @(posedge clk);
        #1;
        if (!hold) v_v[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        chk("idle_wait", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rr  = 1'b1;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
            c_v[i] = 1'b0;
            v_v[i] = 1'b0;
        end
        v_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_sum", 32'(rsp_sum), 32'd0);
        chk("rst_cout", 32'(rsp_cout), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        v_v[0] = 1'b0;
        rst = 1'b0;

        q.push_back('{id: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0});
        issue(0, 8'h0F, 8'h01, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        chk("latency", 32'(n), 32'd9);
        wait_idle();

        q.push_back('{id: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        issue(1, 8'hFF, 8'h01, 1'b0, 1'b0);
        wait_idle();
        q.push_back('{id: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0});
        issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_idle();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.push_back('{id: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0});
        q.push_back('{id: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0});
        q.push_back('{id: 1'b0, sum: 8'h47, cout: 1'b0, ovf: 1'b0});
        q.push_back('{id: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0});
        fork
            begin
                issue(0, 8'h0F, 8'h01, 1'b0, 1'b1);
                issue(0, 8'h12, 8'h34, 1'b1, 1'b0);
            end
            begin
                issue(1, 8'hFF, 8'h01, 1'b0, 1'b1);
                issue(1, 8'hFF, 8'hFF, 1'b1, 1'b0);
            end
        join
        wait_idle();

        rr = 1'b0;
        q.push_back('{id: 1'b0, sum: 8'h4C, cout: 1'b0, ovf: 1'b0});
        issue(0, 8'h3C, 8'h0F, 1'b1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        for (int j = 0; j < 5; j++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_sum", 32'(rsp_sum), 32'h4C);
            chk("stall_id", 32'(rsp_id), 32'd0);
            if (j < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        issue(0, 8'h55, 8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        q.push_back('{id: 1'b0, sum: 8'h77, cout: 1'b0, ovf: 1'b0});
        q.push_back('{id: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b1});
        fork
            issue(0, 8'h55, 8'h22, 1'b0, 1'b0);
            issue(1, 8'h80, 8'h80, 1'b0, 1'b0);
        join
        wait_idle();

        q.push_back('{id: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1});
        issue(0, 8'h7F, 8'h01, 1'b0, 1'b0);
        wait_idle();
        q.push_back('{id: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0});
        issue(0, 8'h01, 8'h01, 1'b0, 1'b0);
        wait_idle();

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_add_arb.md
BIT_SERIAL_ADD_ARB -- requirements
Module: bit_serial_add_arb

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (2..32).
REQ-002 Parameter NREQ, default 2, number of requesters (2..4).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-007 req_a  input  NREQ*WIDTH  operand A, requester i at slice [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  operand B, same packing.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 rsp_valid  output  1  result available.
REQ-011 rsp_ready  input  1  result consumer accept.
REQ-012 rsp_id  output  $clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_sum  output  WIDTH  sum; rsp_cout  output  1  carry-out.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL share one 1-bit full-adder cell among all requesters, computing {cout,sum}=a+b+cin bit-serially, LSB first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE: IDLE->RUN on accept, RUN->DONE after WIDTH bit cycles, DONE->IDLE on rsp_valid&&rsp_ready.
REQ-017 In IDLE, req_ready[i] SHALL be high only for the round-robin winner among asserted req_valid; in RUN and DONE all req_ready bits SHALL be low.
REQ-018 Round-robin SHALL grant the first valid index strictly after last_grant, wrapping from NREQ-1 to 0; last_grant updates only on accept.
REQ-019 On accept at edge k, operands, cin and id SHALL be captured; RUN occupies cycles k+1..k+WIDTH, one bit per cycle; rsp_valid SHALL rise in cycle k+WIDTH+1.
REQ-020 The carry register SHALL load req_cin at accept and feed each bit's carry-out to the next bit; rsp_cout is the carry out of bit WIDTH-1.
REQ-021 In DONE, rsp_valid, rsp_id, rsp_sum and rsp_cout SHALL stay stable until rsp_ready is sampled high.
REQ-022 After the response handshake, req_ready SHALL be available in the next cycle (IDLE), so minimum issue interval is WIDTH+2 cycles.
REQ-023 Requests arriving while busy SHALL be held off (ready low), never dropped or reordered within a requester.
REQ-024 rsp_valid SHALL be low in IDLE and RUN; rsp_sum SHALL show the final value only while in DONE.

Reset
REQ-025 On rst: state=IDLE, rsp_valid=0, req_ready=0 in the reset cycle, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, bit counter=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-026 rst asserted in RUN or DONE SHALL abort the operation; no response for it is ever produced.

Configuration
REQ-027 With SERADD_OVF_EN defined, output rsp_ovf (1 bit) SHALL exist and equal carry-in XOR carry-out of bit WIDTH-1 (two's-complement overflow), valid with rsp_valid, reset 0.
REQ-028 Without SERADD_OVF_EN, rsp_ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package seradd_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH/NREQ constants.
REQ-030 The 1-bit adder SHALL be sub-module fa_cell (a, b, cin -> sum, cout), instantiated once.

Verification
REQ-031 Req0 a=0x0F b=0x01 cin=0 -> rsp_sum=0x10 cout=0 id=0, rsp_valid 9 cycles after accept.
REQ-032 Req1 a=0xFF b=0x01 cin=0 -> rsp_sum=0x00 cout=1 id=1; a=0xFF b=0xFF cin=1 -> 0xFF cout=1.
REQ-033 Both valid from reset, held -> serve order id 0,1,0,1; req_ready never high for both, never high while busy.
REQ-034 rsp_ready held low 5 cycles in DONE -> rsp_valid and payload stable for all 5 cycles; IDLE the cycle after handshake.
REQ-035 rst pulsed at RUN bit 3 -> next cycle busy=0, rsp_valid=0; no stale response follows; next grant goes to requester 0.
REQ-036 With SERADD_OVF_EN: a=0x7F b=0x01 cin=0 -> rsp_sum=0x80 rsp_ovf=1; a=0x01 b=0x01 -> rsp_ovf=0.
